// File: rtl/up_mem_arbiter.sv
// Two-requester (cpu/dma) arbiter in front of a single-port memory.
// Round-robin between requesters, with a cpu lock that keeps cpu priority
// for back-to-back accesses. Writes take 2 cycles and reads take 3.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no access in flight; arbitrates on any req
// ST_ISSUE  | grant pulse to the winner; memory strobe driven
// ST_RDWAIT | memory read data arriving; captured into rdata at the edge
module up_mem_arbiter #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          nRst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   input  logic          cpu_lock,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          cpu_gnt,
   output logic          dma_gnt,
   output logic          cpu_rvalid,
   output logic          dma_rvalid,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   output logic          mem_re,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_RDWAIT = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          we_q, we_d;
   // Owner of the access in flight: 0 = cpu, 1 = dma.
   logic          owner_q, owner_d;
   // Set when the last grant went to cpu, so dma wins the next tie.
   logic          prio_dma_q, prio_dma_d;
   // The last granted access was cpu with cpu_lock set.
   logic          lock_q, lock_d;
   logic          cpu_rvalid_q, cpu_rvalid_d;
   logic          dma_rvalid_q, dma_rvalid_d;
   logic          cpu_win;

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q      <= ST_IDLE;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         rdata_q      <= '0;
         we_q         <= 1'b0;
         owner_q      <= 1'b0;
         prio_dma_q   <= 1'b0;
         lock_q       <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         dma_rvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         rdata_q      <= rdata_d;
         we_q         <= we_d;
         owner_q      <= owner_d;
         prio_dma_q   <= prio_dma_d;
         lock_q       <= lock_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         dma_rvalid_q <= dma_rvalid_d;
      end
   end

   // Next-state logic: arbitration in IDLE, read-data capture in RDWAIT.
   always_comb begin
      state_d      = state_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      rdata_d      = rdata_q;
      we_d         = we_q;
      owner_d      = owner_q;
      prio_dma_d   = prio_dma_q;
      lock_d       = lock_q;
      cpu_rvalid_d = 1'b0;
      dma_rvalid_d = 1'b0;
      // A held cpu lock overrides the round-robin pointer.
      cpu_win      = cpu_req & (~dma_req | lock_q | ~prio_dma_q);
      case (state_q)
         ST_IDLE: begin
            if (cpu_req || dma_req) begin
               state_d     = ST_ISSUE;
               owner_d     = ~cpu_win;
               prio_dma_d  = cpu_win;
               lock_d      = cpu_win & cpu_lock;
               mem_addr_d  = cpu_win ? cpu_addr  : dma_addr;
               mem_wdata_d = cpu_win ? cpu_wdata : dma_wdata;
               we_d        = cpu_win ? cpu_we    : dma_we;
            end
         end
         ST_ISSUE: begin
            state_d = we_q ? ST_IDLE : ST_RDWAIT;
         end
         ST_RDWAIT: begin
            rdata_d      = mem_rdata;
            cpu_rvalid_d = ~owner_q;
            dma_rvalid_d = owner_q;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Grants and strobes decode directly from state so reset clears them at once.
   always_comb begin
      cpu_gnt = (state_q == ST_ISSUE) & ~owner_q;
      dma_gnt = (state_q == ST_ISSUE) &  owner_q;
      mem_we  = (state_q == ST_ISSUE) &  we_q;
      mem_re  = (state_q == ST_ISSUE) & ~we_q;
      busy    = (state_q != ST_IDLE);
   end

   assign cpu_rvalid = cpu_rvalid_q;
   assign dma_rvalid = dma_rvalid_q;
   assign rdata      = rdata_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_up_mem_arbiter.sv
// Directed bench for up_mem_arbiter with a small behavioural memory.
module tb_up_mem_arbiter;
   localparam int AW = 8;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          nRst = 1'b0;
   logic          cpu_req = 1'b0, cpu_we = 1'b0, cpu_lock = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          dma_req = 1'b0, dma_we = 1'b0;
   logic [AW-1:0] dma_addr = '0;
   logic [DW-1:0] dma_wdata = '0;
   logic          cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid;
   logic [DW-1:0] rdata, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic          mem_we, mem_re, busy;
   logic [DW-1:0] mem_rdata = '0;
   logic [DW-1:0] tb_mem [256];

   int n_checks = 0;
   int n_errors = 0;

   up_mem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .nRst(nRst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_lock(cpu_lock),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata),
      .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt),
      .cpu_rvalid(cpu_rvalid), .dma_rvalid(dma_rvalid),
      .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // Memory: read data valid the cycle after mem_re.
   always @(posedge clk) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= tb_mem[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) tb_mem[i] = '0;
      tb_mem[8'h20] = 8'hC3;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_gnt", {cpu_gnt, dma_gnt}, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_strobes", {mem_we, mem_re}, 0);
      nRst = 1'b1;

      // cpu write 0x10 <- 0x5A
      @(negedge clk);
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 8'h5A;
      @(negedge clk);
      chk("wr_cpu_gnt", cpu_gnt, 1);
      chk("wr_dma_gnt", dma_gnt, 0);
      chk("wr_strobes", {mem_we, mem_re}, 2'b10);
      chk("wr_addr", mem_addr, 8'h10);
      chk("wr_wdata", mem_wdata, 8'h5A);
      chk("wr_busy1", busy, 1);
      cpu_req = 0;
      @(negedge clk);
      chk("wr_busy2", busy, 0);
      chk("wr_we2", mem_we, 0);
      chk("wr_gnt2", cpu_gnt, 0);

      // dma read 0x20 -> 0xC3
      dma_req = 1; dma_we = 0; dma_addr = 8'h20;
      @(negedge clk);
      chk("rd_dma_gnt", dma_gnt, 1);
      chk("rd_cpu_gnt", cpu_gnt, 0);
      chk("rd_strobes", {mem_we, mem_re}, 2'b01);
      chk("rd_addr", mem_addr, 8'h20);
      dma_req = 0;
      @(negedge clk);
      chk("rd_c2_busy", busy, 1);
      chk("rd_c2_rvalid", dma_rvalid, 0);
      chk("rd_c2_re", mem_re, 0);
      @(negedge clk);
      chk("rd_c3_rvalid", {cpu_rvalid, dma_rvalid}, 2'b01);
      chk("rd_c3_rdata", rdata, 8'hC3);
      chk("rd_c3_busy", busy, 0);
      @(negedge clk);
      chk("rd_c4_rvalid", dma_rvalid, 0);
      chk("rd_c4_hold", rdata, 8'hC3);

      // Both requesting continuously, no lock: cpu, dma, cpu, dma
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h30; cpu_lock = 0;
      dma_req = 1; dma_we = 1; dma_addr = 8'h40;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("rr_gnt%0d", i), {cpu_gnt, dma_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
         @(negedge clk);
         chk($sformatf("rr_idle%0d", i), busy, 0);
      end
      cpu_req = 0; dma_req = 0;
      @(negedge clk);

      // Lock: cpu(lock=1), cpu(lock=0), then dma
      cpu_req = 1; cpu_lock = 1; dma_req = 1;
      @(negedge clk);
      chk("lk_gnt0", {cpu_gnt, dma_gnt}, 2'b10);
      @(negedge clk);
      cpu_lock = 0;
      @(negedge clk);
      chk("lk_gnt1", {cpu_gnt, dma_gnt}, 2'b10);
      @(negedge clk);
      @(negedge clk);
      chk("lk_gnt2", {cpu_gnt, dma_gnt}, 2'b01);
      cpu_req = 0; dma_req = 0;
      @(negedge clk);

      // cpu read, reset asserted during RDWAIT
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
      @(negedge clk);
      chk("rs_cpu_gnt", cpu_gnt, 1);
      cpu_req = 0;
      @(negedge clk);
      chk("rs_rdwait_busy", busy, 1);
      nRst = 0;
      #1;
      chk("rs_busy", busy, 0);
      chk("rs_gnt", {cpu_gnt, dma_gnt}, 0);
      chk("rs_rvalid", {cpu_rvalid, dma_rvalid}, 0);
      chk("rs_strobes", {mem_we, mem_re}, 0);
      chk("rs_rdata", rdata, 0);
      chk("rs_addr", mem_addr, 0);
      chk("rs_wdata", mem_wdata, 0);
      @(negedge clk);
      @(negedge clk);
      nRst = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("rs_no_rvalid%0d", i), {cpu_rvalid, dma_rvalid, busy}, 0);
      end

      // First arbitration after reset favours cpu
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
      dma_req = 1; dma_we = 0; dma_addr = 8'h10;
      @(negedge clk);
      chk("rs_first_gnt", {cpu_gnt, dma_gnt}, 2'b10);
      cpu_req = 0; dma_req = 0;
      @(negedge clk);
      @(negedge clk);
      chk("rs_rd_rvalid", {cpu_rvalid, dma_rvalid}, 2'b10);
      chk("rs_rd_rdata", rdata, 8'hC3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
